whack_game_controller: RTL and testbench

//  Parametrised main game controller for whack-an-engineer. Sequences the screens
//  (idle, start, play, pause, game over) and owns the game datapath: mole spawn, hit

---
 rtl/whack_game_controller.sv | 170 +++++++++++++++++
 tb/tb_whack_game_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/whack_game_controller.sv
// Whack-an-engineer game controller: screen sequencing plus the game datapath
// (mole spawn from an LFSR, hit matching, saturating score/miss counters and
// the tick-driven countdown). All outputs are registered.
//
// state          | meaning
// S_IDLE         | after reset, moves straight on
// S_START_SCREEN | waiting for start_game
// S_START_GAME   | one cycle, clears the game datapath
// S_IN_GAME      | ticks run, moles spawn, hits are scored
// S_PAUSED       | everything in the game frozen
// S_GAME_OVER    | results held until start_game
module whack_game_controller #(
  parameter int NUM_MOLES  = 5,
  parameter int SCORE_W    = 8,
  parameter int TIME_W     = 6,
  parameter int GAME_TICKS = 60,
  parameter int TICK_DIV   = 50_000_000,
  parameter int MOLE_LIFE  = 3
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_game_i,
  input  logic                 pause_i,
  input  logic [NUM_MOLES-1:0] hit_i,
  output logic [2:0]           state_o,
  output logic [NUM_MOLES-1:0] moles_up_o,
  output logic [SCORE_W-1:0]   score_o,
  output logic [SCORE_W-1:0]   misses_o,
  output logic [TIME_W-1:0]    time_left_o,
  output logic                 hit_pulse_o
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LIFE_W = $clog2(MOLE_LIFE + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_START_SCREEN = 3'd1,
    S_START_GAME   = 3'd2,
    S_IN_GAME      = 3'd3,
    S_PAUSED       = 3'd4,
    S_GAME_OVER    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [LIFE_W-1:0]    life_q, life_d;
  logic [NUM_MOLES-1:0] moles_q, moles_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   misses_q, misses_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [NUM_MOLES-1:0] hit_prev_q;
  logic                 hit_pulse_q, hit_pulse_d;

  logic                 hit_edge, hit_match, tick, expire, wrong_hit;
  logic [7:0]           spawn_idx;
  logic [NUM_MOLES-1:0] spawn_mask;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + SCORE_W'(1) : v;
  endfunction

  assign hit_edge   = (|hit_i) & ~(|hit_prev_q);
  assign hit_match  = |(hit_i & moles_q);
  assign spawn_idx  = lfsr_q[7:0] % 8'(NUM_MOLES);
  assign spawn_mask = NUM_MOLES'(1) << spawn_idx;

  // State and datapath registers; reset clears everything and seeds the LFSR.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      lfsr_q      <= 16'hACE1;
      life_q      <= '0;
      moles_q     <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      time_q      <= '0;
      hit_prev_q  <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      lfsr_q      <= lfsr_d;
      life_q      <= life_d;
      moles_q     <= moles_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      time_q      <= time_d;
      hit_prev_q  <= hit_i;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  // Next-state and game datapath; everything holds unless IN_GAME is running unpaused.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    life_d      = life_q;
    moles_d     = moles_q;
    score_d     = score_q;
    misses_d    = misses_q;
    time_d      = time_q;
    hit_pulse_d = 1'b0;
    tick        = 1'b0;
    expire      = 1'b0;
    wrong_hit   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_START_SCREEN;
      S_START_SCREEN: if (start_game_i) state_d = S_START_GAME;
      S_START_GAME: begin
        score_d    = '0;
        misses_d   = '0;
        time_d     = TIME_W'(GAME_TICKS);
        moles_d    = '0;
        life_d     = '0;
        tick_cnt_d = '0;
        state_d    = S_IN_GAME;
      end
      S_IN_GAME: begin
        // Pause wins over everything else this cycle, including a final tick.
        if (pause_i) begin
          state_d = S_PAUSED;
        end else begin
          tick       = (tick_cnt_q == TICK_LAST);
          tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
          if (moles_q == '0) begin
            moles_d = spawn_mask;
            life_d  = LIFE_W'(MOLE_LIFE);
          end else if (tick) begin
            life_d = life_q - LIFE_W'(1);
            if (life_q == LIFE_W'(1)) begin
              moles_d = '0;
              expire  = 1'b1;
            end
          end
          if (hit_edge) begin
            if (hit_match) begin
              score_d     = sat_inc(score_q, 1'b1);
              hit_pulse_d = 1'b1;
              moles_d     = '0;
              expire      = 1'b0;
            end else begin
              wrong_hit = 1'b1;
            end
          end
          misses_d = sat_inc(sat_inc(misses_q, wrong_hit), expire);
          if (tick) begin
            time_d = time_q - TIME_W'(1);
            if (time_q == TIME_W'(1)) state_d = S_GAME_OVER;
          end
        end
      end
      S_PAUSED: if (!pause_i) state_d = S_IN_GAME;
      S_GAME_OVER: if (start_game_i) state_d = S_START_SCREEN;
      default: state_d = S_IDLE;
    endcase
  end

  assign state_o     = state_q;
  assign moles_up_o  = moles_q;
  assign score_o     = score_q;
  assign misses_o    = misses_q;
  assign time_left_o = time_q;
  assign hit_pulse_o = hit_pulse_q;

endmodule

// File: tb/tb_whack_game_controller.sv
// Bench for whack_game_controller: a short game instance (3 ticks) driven from
// a vector table, and a long game instance with 2-bit counters for hits,
// misses, expiry, saturation, pause and async reset.
module tb_whack_game_controller;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       start_a = 0, pause_a = 0;
  logic [4:0] hit_a = 0;
  logic [2:0] state_a;
  logic [4:0] moles_a;
  logic [7:0] score_a, misses_a;
  logic [5:0] time_a;
  logic       pulse_a;

  logic       start_b = 0, pause_b = 0;
  logic [4:0] hit_b = 0;
  logic [2:0] state_b;
  logic [4:0] moles_b;
  logic [1:0] score_b, misses_b;
  logic [5:0] time_b;
  logic       pulse_b;

  whack_game_controller #(.NUM_MOLES(5), .SCORE_W(8), .TIME_W(6), .GAME_TICKS(3),
                          .TICK_DIV(4), .MOLE_LIFE(3)) u_short (
    .clock_i(clock), .reset_i(reset), .start_game_i(start_a), .pause_i(pause_a),
    .hit_i(hit_a), .state_o(state_a), .moles_up_o(moles_a), .score_o(score_a),
    .misses_o(misses_a), .time_left_o(time_a), .hit_pulse_o(pulse_a));

  whack_game_controller #(.NUM_MOLES(5), .SCORE_W(2), .TIME_W(6), .GAME_TICKS(40),
                          .TICK_DIV(4), .MOLE_LIFE(3)) u_long (
    .clock_i(clock), .reset_i(reset), .start_game_i(start_b), .pause_i(pause_b),
    .hit_i(hit_b), .state_o(state_b), .moles_up_o(moles_b), .score_o(score_b),
    .misses_o(misses_b), .time_left_o(time_b), .hit_pulse_o(pulse_b));

  // Reference LFSR; m_prev is the value the design used on the most recent edge.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  int passed = 0, total = 0;
  int b_run = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic step_b();
    step();
    b_run++;
  endtask

  function automatic logic [4:0] pred_mole();
    int idx;
    idx = int'(m_prev[7:0]) % 5;
    return 5'b00001 << idx;
  endfunction

  typedef struct {
    logic start;
    int   st;
    int   tl;
    int   sc;
    int   ms;
  } vec_t;
  vec_t vecs[22];

  logic [4:0] cur;
  logic [4:0] wrong;
  int         spawn_edge;
  bit         found;

  initial begin
    vecs[0]  = '{0, 1, 0, 0, 0};  vecs[1]  = '{0, 1, 0, 0, 0};
    vecs[2]  = '{1, 2, 0, 0, 0};  vecs[3]  = '{0, 3, 3, 0, 0};
    vecs[4]  = '{0, 3, 3, 0, 0};  vecs[5]  = '{0, 3, 3, 0, 0};
    vecs[6]  = '{0, 3, 3, 0, 0};  vecs[7]  = '{0, 3, 2, 0, 0};
    vecs[8]  = '{0, 3, 2, 0, 0};  vecs[9]  = '{0, 3, 2, 0, 0};
    vecs[10] = '{0, 3, 2, 0, 0};  vecs[11] = '{0, 3, 1, 0, 0};
    vecs[12] = '{0, 3, 1, 0, 0};  vecs[13] = '{0, 3, 1, 0, 0};
    vecs[14] = '{0, 3, 1, 0, 0};  vecs[15] = '{0, 5, 0, 0, 1};
    vecs[16] = '{0, 5, 0, 0, 1};  vecs[17] = '{0, 5, 0, 0, 1};
    vecs[18] = '{1, 1, 0, 0, 1};  vecs[19] = '{0, 1, 0, 0, 1};
    vecs[20] = '{1, 2, 0, 0, 1};  vecs[21] = '{0, 3, 3, 0, 0};

    #1 reset = 1'b1;
    #11;
    chk("rst_state", int'(state_a), 0);
    chk("rst_moles", int'(moles_a), 0);
    chk("rst_score", int'(score_a), 0);
    chk("rst_misses", int'(misses_a), 0);
    chk("rst_time", int'(time_a), 0);
    reset = 1'b0;
    #1;
    chk("rel_state", int'(state_a), 0);

    // Short game: screen flow, countdown, expiry on the final tick, replay.
    for (int i = 0; i < 22; i++) begin
      start_a = vecs[i].start;
      step();
      chk($sformatf("vec%0d_state", i), int'(state_a), vecs[i].st);
      chk($sformatf("vec%0d_time", i), int'(time_a), vecs[i].tl);
      chk($sformatf("vec%0d_score", i), int'(score_a), vecs[i].sc);
      chk($sformatf("vec%0d_misses", i), int'(misses_a), vecs[i].ms);
    end
    start_a = 0;

    // Short game 2: hit landing on the final tick, same edge as expiry.
    step();
    cur = pred_mole();
    chk("a_spawn", int'(moles_a), int'(cur));
    repeat (10) step();
    chk("a_pre_state", int'(state_a), 3);
    chk("a_pre_time", int'(time_a), 1);
    chk("a_pre_moles", int'(moles_a), int'(cur));
    hit_a = cur;
    step();
    chk("a_final_pulse", int'(pulse_a), 1);
    chk("a_final_score", int'(score_a), 1);
    chk("a_final_misses", int'(misses_a), 0);
    chk("a_final_state", int'(state_a), 5);
    chk("a_final_time", int'(time_a), 0);
    hit_a = 0;
    step();
    chk("a_pulse_drop", int'(pulse_a), 0);
    chk("a_hold_state", int'(state_a), 5);

    // Long game start.
    start_b = 1;
    step();
    chk("b_start_state", int'(state_b), 2);
    start_b = 0;
    step();
    chk("b_ingame_state", int'(state_b), 3);
    chk("b_ingame_time", int'(time_b), 40);

    // Hit with no mole up is a miss; the mole still spawns.
    hit_b = 5'b00001;
    step_b();
    cur = pred_mole();
    chk("b_nomole_misses", int'(misses_b), 1);
    chk("b_nomole_score", int'(score_b), 0);
    chk("b_spawn1", int'(moles_b), int'(cur));
    hit_b = 0;
    step_b();

    // Correct hit, then held button.
    hit_b = cur;
    step_b();
    chk("b_hit_pulse", int'(pulse_b), 1);
    chk("b_hit_score", int'(score_b), 1);
    chk("b_hit_clear", int'(moles_b), 0);
    step_b();
    cur = pred_mole();
    chk("b_respawn", int'(moles_b), int'(cur));
    chk("b_pulse_1cyc", int'(pulse_b), 0);
    step_b();
    chk("b_held_score", int'(score_b), 1);
    chk("b_held_misses", int'(misses_b), 1);
    hit_b = 0;
    step_b();

    // Wrong button.
    wrong = (cur == 5'b00001) ? 5'b00010 : 5'b00001;
    hit_b = wrong;
    step_b();
    chk("b_wrong_misses", int'(misses_b), 2);
    chk("b_wrong_score", int'(score_b), 1);
    chk("b_wrong_moles", int'(moles_b), int'(cur));
    hit_b = 0;
    step_b();

    // Four more hits: score saturates at 3.
    for (int k = 2; k <= 5; k++) begin
      hit_b = cur;
      step_b();
      chk($sformatf("b_sat_score%0d", k), int'(score_b), (k > 3) ? 3 : k);
      hit_b = 0;
      step_b();
      cur = pred_mole();
      chk($sformatf("b_sat_spawn%0d", k), int'(moles_b), int'(cur));
    end
    spawn_edge = b_run;

    // Unhit mole expires on its third tick.
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      step_b();
      if (moles_b == 5'b0) found = 1;
    end
    chk("b_expire_seen", int'(found), 1);
    chk("b_expire_edge", b_run, (spawn_edge / 4 + 3) * 4);
    chk("b_expire_misses", int'(misses_b), 3);
    step_b();
    cur = pred_mole();
    chk("b_expire_respawn", int'(moles_b), int'(cur));

    // Pause for 20 cycles; hits ignored.
    pause_b = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) hit_b = cur;
      if (i == 10) hit_b = 0;
      step();
    end
    chk("b_pause_state", int'(state_b), 4);
    chk("b_pause_time", int'(time_b), 40 - b_run / 4);
    chk("b_pause_moles", int'(moles_b), int'(cur));
    chk("b_pause_score", int'(score_b), 3);
    chk("b_pause_misses", int'(misses_b), 3);
    chk("b_pause_pulse", int'(pulse_b), 0);
    pause_b = 0;
    step();
    chk("b_resume_state", int'(state_b), 3);
    chk("b_resume_time", int'(time_b), 40 - b_run / 4);
    while (b_run % 4 != 3) step_b();
    chk("b_pretick_time", int'(time_b), 40 - b_run / 4);
    step_b();
    chk("b_tick_time", int'(time_b), 40 - b_run / 4);

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    #1;
    chk("arst_state", int'(state_b), 0);
    chk("arst_score", int'(score_b), 0);
    chk("arst_misses", int'(misses_b), 0);
    chk("arst_moles", int'(moles_b), 0);
    chk("arst_time", int'(time_b), 0);
    chk("arst_state_a", int'(state_a), 0);
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("arst_release", int'(state_b), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
